wb_lo_ext_mem_if: RTL and testbench

Wishbone slave that terminates the 16-bit low-side bus from the 32-to-16/8 size bridge. It drives an external asynchronous SRAM/flash-style device with parameterised setup, access and hold phases, and supports a device-driven wait input with a timeout. Each Wishbone access runs exactly one external cycle and returns exactly one single-cycle ack, so the upstream bridge can chain 2 or 4 chunks by holding stb.

---
 rtl/wb_lo_ext_mem_if.sv | 213 +++++++++++++++++++++
 tb/tb_wb_lo_ext_mem_if.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_lo_ext_mem_if.sv
// Wishbone slave for the 16-bit low-side bus of the 32-to-16/8 size bridge.
// Each Wishbone request runs one external SRAM/flash-style cycle
// (SETUP, ACCESS, HOLD), then returns exactly one single-cycle ack or err.
// ACCESS can be stretched by the device wait input, up to a timeout.
// Every output comes from a register. Each output register is loaded from
// the next state and the next latched request, so the pins change on the
// same edge as the state.
module wb_lo_ext_mem_if #(
  parameter int ADDR_W      = 24,
  parameter int SETUP_CYC   = 1,
  parameter int ACCESS_CYC  = 4,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              wb_lo_clk_i,
  input  logic              wb_lo_rst_i,
  input  logic [31:0]       wb_lo_adr_i,
  input  logic [15:0]       wb_lo_dat_i,
  output logic [15:0]       wb_lo_dat_o,
  input  logic              wb_lo_cyc_i,
  input  logic              wb_lo_stb_i,
  input  logic              wb_lo_we_i,
  input  logic [1:0]        wb_lo_sel_i,
  output logic              wb_lo_ack_o,
  output logic              wb_lo_err_o,
  output logic              wb_lo_rty_o,
  input  logic              mem_byte_if_i,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [15:0]       mem_dat_o,
  input  logic [15:0]       mem_dat_i,
  output logic              mem_dat_oe_o,
  output logic              mem_ce_n_o,
  output logic              mem_oe_n_o,
  output logic              mem_we_n_o,
  output logic [1:0]        mem_be_n_o,
  input  logic              mem_wait_i
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_ACCESS   = 3'd2;
  localparam logic [2:0] ST_HOLD     = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;
  localparam logic [2:0] ST_DONE_ERR = 3'd5;

  // Each phase counter starts at 0 on phase entry, so the last cycle of a
  // phase is at count (length - 1).
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] ACC_LAST   = 8'(ACCESS_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TOUT_LAST  = 8'(TIMEOUT_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              tout_q, tout_d;
  logic              abort_q, abort_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [15:0]       wdat_q, wdat_d;
  logic [15:0]       rdat_q, rdat_d;

  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [1:0]        be_n_q, be_n_d;
  logic              dat_oe_q, dat_oe_d;

  logic              busy_q, busy_d, acc_d;

  // Not every address bit reaches the device in both bus modes.
  logic              unused_adr;
  assign unused_adr = ^wb_lo_adr_i;

  assign busy_q = (state_q == ST_SETUP) || (state_q == ST_ACCESS) || (state_q == ST_HOLD);

  // Phase sequencing, request latching and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    tout_d  = tout_q;
    abort_d = abort_q;
    we_d    = we_q;
    byte_d  = byte_q;
    lane_d  = lane_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    // If the master drops cyc while the external cycle is in progress, the
    // cycle still runs to the end, but no response is given.
    if (busy_q && !wb_lo_cyc_i) abort_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (wb_lo_cyc_i && wb_lo_stb_i) begin
          if (wb_lo_sel_i != 2'b00) begin
            state_d = ST_SETUP;
            we_d    = wb_lo_we_i;
            byte_d  = mem_byte_if_i;
            tout_d  = 1'b0;
            abort_d = 1'b0;
            if (mem_byte_if_i) begin
              lane_d = 2'b10;
              adr_d  = wb_lo_adr_i[ADDR_W-1:0];
              wdat_d = {8'h00, wb_lo_dat_i[7:0]};
            end else begin
              lane_d = ~wb_lo_sel_i;
              adr_d  = wb_lo_adr_i[ADDR_W:1];
              wdat_d = wb_lo_dat_i;
            end
          end else begin
            state_d = ST_DONE_ERR;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_ACCESS;
          cnt_d   = 8'd0;
        end
      end
      ST_ACCESS: begin
        if (cnt_q >= ACC_LAST) begin
          if (!mem_wait_i || (cnt_q == TOUT_LAST)) begin
            state_d = ST_HOLD;
            cnt_d   = 8'd0;
            tout_d  = mem_wait_i;
            if (!we_q) rdat_d = byte_q ? {mem_dat_i[7:0], mem_dat_i[7:0]} : mem_dat_i;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_DONE;
          cnt_d   = 8'd0;
        end
      end
      ST_DONE:     state_d = ST_IDLE;
      ST_DONE_ERR: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Pin values for the next cycle, taken from the state being entered.
  always_comb begin
    busy_d   = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
    acc_d    = (state_d == ST_ACCESS);
    ce_n_d   = !busy_d;
    oe_n_d   = !(acc_d && !we_d);
    we_n_d   = !(acc_d && we_d);
    dat_oe_d = busy_d && we_d;
    be_n_d   = busy_d ? lane_d : 2'b11;
    ack_d    = (state_d == ST_DONE) && !tout_d && !abort_d;
    err_d    = ((state_d == ST_DONE) && tout_d && !abort_d) || (state_d == ST_DONE_ERR);
  end

  // State, counters, latched request and registered outputs.
  always_ff @(posedge wb_lo_clk_i) begin
    if (wb_lo_rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      tout_q   <= 1'b0;
      abort_q  <= 1'b0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      lane_q   <= 2'b11;
      adr_q    <= '0;
      wdat_q   <= 16'h0000;
      rdat_q   <= 16'h0000;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      be_n_q   <= 2'b11;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tout_q   <= tout_d;
      abort_q  <= abort_d;
      we_q     <= we_d;
      byte_q   <= byte_d;
      lane_q   <= lane_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      be_n_q   <= be_n_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  assign wb_lo_dat_o  = rdat_q;
  assign wb_lo_ack_o  = ack_q;
  assign wb_lo_err_o  = err_q;
  assign wb_lo_rty_o  = 1'b0;
  assign mem_adr_o    = adr_q;
  assign mem_dat_o    = wdat_q;
  assign mem_dat_oe_o = dat_oe_q;
  assign mem_ce_n_o   = ce_n_q;
  assign mem_oe_n_o   = oe_n_q;
  assign mem_we_n_o   = we_n_q;
  assign mem_be_n_o   = be_n_q;

endmodule

// File: tb/tb_wb_lo_ext_mem_if.sv
// Directed bench for wb_lo_ext_mem_if with default parameters.
// Each transfer is modelled as a set of phase intervals in absolute cycle
// numbers. A compare process checks every output against those intervals
// on every cycle. Literal expectations pin latencies and mapped values.
module tb_wb_lo_ext_mem_if;
  localparam int AW = 24, S = 1, A = 4, H = 1, TO = 255;

  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] adr_i = '0;
  logic [15:0] dat_i = '0, dat_o, mdat_o, mdat_i = '0;
  logic cyc_i = 0, stb_i = 0, we_i = 0, ack_o, err_o, rty_o, byte_i = 0;
  logic [1:0] sel_i = '0, be_n_o;
  logic [AW-1:0] madr_o;
  logic doe_o, ce_n_o, oe_n_o, we_n_o, wait_i = 0;

  wb_lo_ext_mem_if #(.ADDR_W(AW), .SETUP_CYC(S), .ACCESS_CYC(A), .HOLD_CYC(H), .TIMEOUT_CYC(TO)) dut (
    .wb_lo_clk_i(clk), .wb_lo_rst_i(rst), .wb_lo_adr_i(adr_i), .wb_lo_dat_i(dat_i),
    .wb_lo_dat_o(dat_o), .wb_lo_cyc_i(cyc_i), .wb_lo_stb_i(stb_i), .wb_lo_we_i(we_i),
    .wb_lo_sel_i(sel_i), .wb_lo_ack_o(ack_o), .wb_lo_err_o(err_o), .wb_lo_rty_o(rty_o),
    .mem_byte_if_i(byte_i), .mem_adr_o(madr_o), .mem_dat_o(mdat_o), .mem_dat_i(mdat_i),
    .mem_dat_oe_o(doe_o), .mem_ce_n_o(ce_n_o), .mem_oe_n_o(oe_n_o), .mem_we_n_o(we_n_o),
    .mem_be_n_o(be_n_o), .mem_wait_i(wait_i));

  always #5 clk = ~clk;

  int cnum = 0;
  always @(posedge clk) cnum <= cnum + 1;

  typedef struct {
    bit valid, errsel, we, to, ab;
    int p, a0, h0, d;
    logic [1:0] be;
    logic [AW-1:0] adr, padr;
    logic [15:0] mdat, pmdat, rdat, prdat;
  } rec_t;

  rec_t r;
  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;
  int m_oe, m_we, m_doe, m_ce, m_ack, m_err, ack_at, err_at;
  logic [AW-1:0] adr_seen;
  logic [1:0] be_seen;
  logic [15:0] mdat_seen;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cnum, act, exp);
  endtask

  function automatic logic [AW-1:0] fin_adr(input rec_t x);
    return (x.valid && !x.errsel) ? x.adr : x.padr;
  endfunction
  function automatic logic [15:0] fin_mdat(input rec_t x);
    return (x.valid && !x.errsel) ? x.mdat : x.pmdat;
  endfunction
  function automatic logic [15:0] fin_rdat(input rec_t x);
    return (x.valid && !x.errsel && !x.we) ? x.rdat : x.prdat;
  endfunction

  task automatic model_reset();
    r.valid = 0; r.errsel = 0; r.padr = '0; r.pmdat = '0; r.prdat = '0;
  endtask

  task automatic clr_mon();
    m_oe = 0; m_we = 0; m_doe = 0; m_ce = 0; m_ack = 0; m_err = 0;
    ack_at = -1; err_at = -1; adr_seen = '0; be_seen = 2'b11; mdat_seen = '0;
  endtask

  // Expected outputs for the current cycle, from the phase intervals of the active transfer
  logic e_busy, e_acc, e_ack, e_err;
  logic [1:0] e_be;
  logic [AW-1:0] e_adr;
  logic [15:0] e_rdat, e_mdat;
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      e_busy = 0; e_acc = 0; e_ack = 0; e_err = 0;
      e_adr = r.padr; e_rdat = r.prdat; e_mdat = r.pmdat;
      if (r.valid && r.errsel) begin
        e_err = (cnum == r.p + 1);
      end else if (r.valid) begin
        e_busy = (cnum >= r.p + 1) && (cnum < r.d);
        e_acc  = (cnum >= r.a0) && (cnum < r.h0);
        if (cnum >= r.p + 1) e_adr = r.adr;
        if (!r.we && cnum >= r.h0) e_rdat = r.rdat;
        e_mdat = r.mdat;
        e_ack = (cnum == r.d) && !r.to && !r.ab;
        e_err = (cnum == r.d) && r.to && !r.ab;
      end
      e_be = e_busy ? r.be : 2'b11;
      check("ctl{ack,err,rty,ce_n,oe_n,we_n,be_n,dat_oe}",
            {ack_o, err_o, rty_o, ce_n_o, oe_n_o, we_n_o, be_n_o, doe_o},
            {e_ack, e_err, 1'b0, !e_busy, !(e_acc && !r.we), !(e_acc && r.we), e_be, e_busy && r.we});
      check("mem_adr", madr_o, e_adr);
      check("wb_dat_o", dat_o, e_rdat);
      if ((e_busy && r.we) || !r.valid) check("mem_dat_o", mdat_o, r.valid ? e_mdat : 16'h0000);
      if (!oe_n_o) m_oe++;
      if (!we_n_o) m_we++;
      if (doe_o) begin m_doe++; mdat_seen = mdat_o; end
      if (!ce_n_o) begin m_ce++; adr_seen = madr_o; be_seen = be_n_o; end
      if (ack_o) begin m_ack++; ack_at = cnum; end
      if (err_o) begin m_err++; err_at = cnum; end
    end
  end

  // One external transfer; called at a negedge with the DUT idle, returns at the negedge of the sampling cycle for a follow-on request
  task automatic xfer(input logic [31:0] adr, input logic [15:0] dat, input bit we, input logic [1:0] sel,
                      input bit bm, input int w, input logic [15:0] rd, input int drop, input int rst_at,
                      input bit flipwe, input bit chain, output int p_o);
    rec_t n;
    int p, L;
    p = cnum; p_o = p;
    cyc_i = 1; stb_i = 1; adr_i = adr; dat_i = dat; we_i = we; sel_i = sel; byte_i = bm;
    mdat_i = rd; wait_i = (w > 0);
    L = (A + w > TO) ? TO : A + w;
    n.valid = 1; n.errsel = 0; n.we = we; n.to = (A + w > TO); n.ab = (drop > 0);
    n.p = p; n.a0 = p + S + 1; n.h0 = n.a0 + L; n.d = n.h0 + H;
    n.be   = bm ? 2'b10 : ~sel;
    n.adr  = bm ? adr[AW-1:0] : adr[AW:1];
    n.mdat = bm ? {8'h00, dat[7:0]} : dat;
    n.rdat = bm ? {rd[7:0], rd[7:0]} : rd;
    n.padr = fin_adr(r); n.pmdat = fin_mdat(r); n.prdat = fin_rdat(r);
    r = n;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      wait_i = (w > 0) && (cnum <= r.a0 + A + w - 2);
      if (flipwe && cnum == r.a0) we_i = ~we;
      if (drop > 0 && cnum == p + drop) begin cyc_i = 0; stb_i = 0; end
      if (rst_at > 0 && cnum == p + rst_at) begin
        rst = 1; cyc_i = 0; stb_i = 0; wait_i = 0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 0;
        return;
      end
      if (cnum == r.d && !chain) begin cyc_i = 0; stb_i = 0; end
      if (cnum == r.d + 1) break;
    end
  endtask

  task automatic errsel(output int p_o);
    rec_t n;
    p_o = cnum;
    cyc_i = 1; stb_i = 1; sel_i = 2'b00; we_i = 0;
    n = r; n.valid = 1; n.errsel = 1; n.p = cnum;
    n.padr = fin_adr(r); n.pmdat = fin_mdat(r); n.prdat = fin_rdat(r);
    r = n;
    @(negedge clk); cyc_i = 0; stb_i = 0;
    @(negedge clk);
  endtask

  initial begin
    int p;
    logic [15:0] rds [4];
    rds[0] = 16'hA511; rds[1] = 16'hA522; rds[2] = 16'hA533; rds[3] = 16'hA544;
    model_reset(); clr_mon();
    @(posedge clk); chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    @(negedge clk);

    // 16-bit read with default timing
    clr_mon();
    xfer(32'h0000_1234, 16'h0000, 0, 2'b11, 0, 0, 16'hBEEF, 0, 0, 0, 0, p);
    check("t1_ack_latency", ack_at - p, 7);
    check("t1_oe_low_cycles", m_oe, 4);
    check("t1_mem_adr", adr_seen, 24'h00091A);
    check("t1_read_data", dat_o, 16'hBEEF);
    check("t1_ack_count", m_ack, 1);

    // 16-bit write, low lane only; we flipped mid-access must be ignored
    clr_mon();
    xfer(32'h0000_2000, 16'hA55A, 1, 2'b01, 0, 0, 16'h0000, 0, 0, 1, 0, p);
    check("t2_we_low_cycles", m_we, 4);
    check("t2_oe_low_cycles", m_oe, 0);
    check("t2_be_n", be_seen, 2'b10);
    check("t2_mem_dat", mdat_seen, 16'hA55A);
    check("t2_dat_oe_cycles", m_doe, 6);
    check("t2_ack_count", m_ack, 1);

    // Wait stretch of 3 cycles
    clr_mon();
    xfer(32'h0000_0040, 16'h0000, 0, 2'b11, 0, 3, 16'h1357, 0, 0, 0, 0, p);
    check("t3_ack_latency", ack_at - p, 10);
    check("t3_oe_low_cycles", m_oe, 7);

    // Wait held past the timeout on a write
    clr_mon();
    xfer(32'h0000_0080, 16'h5AA5, 1, 2'b11, 0, 300, 16'h0000, 0, 0, 0, 0, p);
    check("t3_timeout_err", m_err, 1);
    check("t3_timeout_ack", m_ack, 0);
    check("t3_timeout_we_low", m_we, 255);
    check("t3_timeout_err_latency", err_at - p, 258);

    // Wait released exactly at the last allowed ACCESS cycle
    clr_mon();
    xfer(32'h0000_00C0, 16'h0000, 0, 2'b11, 0, TO - A, 16'h2468, 0, 0, 0, 0, p);
    check("t3_edge_ack", m_ack, 1);
    check("t3_edge_err", m_err, 0);
    check("t3_edge_oe_low", m_oe, 255);

    // 8-bit device, stb held across four chunks
    clr_mon();
    for (int i = 0; i < 4; i++)
      xfer(32'h0000_0100 + i, 16'h0000, 0, 2'b11, 1, 0, rds[i], 0, 0, 0, i < 3, p);
    check("t4_ack_count", m_ack, 4);
    check("t4_ce_low_cycles", m_ce, 24);
    check("t4_last_data", dat_o, 16'h4444);
    check("t4_last_adr", adr_seen, 24'h000103);
    clr_mon();
    xfer(32'h0000_0105, 16'h12C3, 1, 2'b11, 1, 0, 16'h0000, 0, 0, 0, 0, p);
    check("t4_byte_wdat", mdat_seen, 16'h00C3);
    check("t4_byte_be_n", be_seen, 2'b10);
    check("t4_byte_adr", adr_seen, 24'h000105);

    // Empty lane select
    clr_mon();
    errsel(p);
    check("t5_err_latency", err_at - p, 1);
    check("t5_ce_low_cycles", m_ce, 0);
    check("t5_ack_count", m_ack, 0);

    // Reset in ACCESS, then a normal read
    clr_mon();
    xfer(32'h0000_0010, 16'h0000, 0, 2'b11, 0, 0, 16'hCAFE, 0, 3, 0, 0, p);
    check("t6_no_ack", m_ack, 0);
    check("t6_ce_after_reset", ce_n_o, 1'b1);
    clr_mon();
    xfer(32'h0000_0002, 16'h0000, 0, 2'b11, 0, 0, 16'h0F0F, 0, 0, 0, 0, p);
    check("t6_ack_latency", ack_at - p, 7);
    check("t6_read_data", dat_o, 16'h0F0F);
    check("t6_mem_adr", adr_seen, 24'h000001);

    // cyc dropped mid-transfer: full external cycle, no response
    clr_mon();
    xfer(32'h0000_0020, 16'h0000, 0, 2'b11, 0, 0, 16'h7777, 3, 0, 0, 0, p);
    check("t7_no_ack", m_ack, 0);
    check("t7_no_err", m_err, 0);
    check("t7_oe_low_cycles", m_oe, 4);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
